// File: rtl/parity_seq_ctrl.sv
// Nibble-serial parity controller: captures a word, runs it through one 4-bit
// parity unit one nibble per cycle, then presents word, parity and check errors.
module parity_seq_ctrl #(
  parameter int NIBBLES = 4,
  parameter bit ODD     = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_data,
  input  logic                   in_mode,
  input  logic [NIBBLES-1:0]     in_parity,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_data,
  output logic [NIBBLES-1:0]     out_parity,
  output logic [NIBBLES-1:0]     out_err,
  output logic                   busy
);

  localparam int DW = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DW-1:0]       data_q, data_d;
  logic                mode_q, mode_d;
  logic [NIBBLES-1:0]  exp_q, exp_d;
  logic [NIBBLES-1:0]  acc_q, acc_d;
  logic [DW-1:0]       out_data_q, out_data_d;
  logic [NIBBLES-1:0]  out_parity_q, out_parity_d;
  logic [NIBBLES-1:0]  out_err_q, out_err_d;

  logic [3:0]          nib;
  logic                par_bit;

  // The single shared parity unit, steered by the nibble index.
  always_comb begin
    nib     = data_q[{idx_q, 2'b00} +: 4];
    par_bit = ODD ? ~(^nib) : (^nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)             state_d = CALC;
      CALC:    if (idx_q == LAST_IDX)    state_d = DONE;
      DONE:    if (out_ready)            state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    idx_d        = idx_q;
    data_d       = data_q;
    mode_d       = mode_q;
    exp_d        = exp_q;
    acc_d        = acc_q;
    out_data_d   = out_data_q;
    out_parity_d = out_parity_q;
    out_err_d    = out_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          mode_d = in_mode;
          exp_d  = in_parity;
          acc_d  = '0;
          idx_d  = '0;
        end
      end
      CALC: begin
        acc_d[idx_q] = par_bit;
        if (idx_q == LAST_IDX) begin
          // Result registers load only here, so they hold through IDLE and the next CALC.
          out_data_d   = data_q;
          out_parity_d = acc_d;
          out_err_d    = mode_q ? (acc_d ^ exp_q) : '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      data_q       <= '0;
      mode_q       <= 1'b0;
      exp_q        <= '0;
      acc_q        <= '0;
      out_data_q   <= '0;
      out_parity_q <= '0;
      out_err_q    <= '0;
    end else begin
      idx_q        <= idx_d;
      data_q       <= data_d;
      mode_q       <= mode_d;
      exp_q        <= exp_d;
      acc_q        <= acc_d;
      out_data_q   <= out_data_d;
      out_parity_q <= out_parity_d;
      out_err_q    <= out_err_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_parity = out_parity_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_parity_seq_ctrl.sv
// Bench for parity_seq_ctrl: an odd-parity and an even-parity instance share
// stimulus and are checked against a counting-based parity model.
module tb_parity_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic [3:0]  in_parity = '0;

  logic        in_ready_o, out_valid_o, busy_o;
  logic        in_ready_e, out_valid_e, busy_e;
  logic [15:0] out_data_o, out_data_e;
  logic [3:0]  out_parity_o, out_parity_e, out_err_o, out_err_e;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  parity_seq_ctrl #(.NIBBLES(4), .ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o),
    .in_data(in_data), .in_mode(in_mode), .in_parity(in_parity),
    .out_valid(out_valid_o), .out_ready(out_ready), .out_data(out_data_o),
    .out_parity(out_parity_o), .out_err(out_err_o), .busy(busy_o)
  );

  parity_seq_ctrl #(.NIBBLES(4), .ODD(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_e),
    .in_data(in_data), .in_mode(in_mode), .in_parity(in_parity),
    .out_valid(out_valid_e), .out_ready(out_ready), .out_data(out_data_e),
    .out_parity(out_parity_e), .out_err(out_err_e), .busy(busy_e)
  );

  // Parity bit chosen so nibble plus bit has an odd (or even) count of ones.
  function automatic logic [3:0] model_par(input logic [15:0] w, input bit odd);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) begin
      int cnt;
      cnt = $countones(w[4*k +: 4]);
      r[k] = odd ? (cnt % 2 == 0) : (cnt % 2 == 1);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a word, waits for acceptance, then for out_valid; lat counts cycles
  // from the handshake cycle to the first cycle with out_valid high.
  task automatic run_word(input logic [15:0] d, input logic m, input logic [3:0] p,
                          output int lat);
    int n;
    in_data = d; in_mode = m; in_parity = p; in_valid = 1'b1;
    n = 0;
    while (!in_ready_o && n < 50) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    in_data = $urandom; in_mode = $urandom; in_parity = $urandom;
    lat = 1;
    while (!out_valid_o && lat < 50) begin tick(); lat++; end
    tests_run++;
    if (!out_valid_o) begin
      tests_failed++;
      $display("FAIL run_word_timeout: out_valid=%b after %0d cycles, expected 1", out_valid_o, lat);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests_run++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || out_data_o !== 16'h0 ||
        out_parity_o !== 4'h0 || out_err_o !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b busy=%b data=%h par=%b err=%b, expected all 0",
               out_valid_o, busy_o, out_data_o, out_parity_o, out_err_o);
    end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (in_ready_o !== 1'b1 || in_ready_e !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b/%b, expected 1/1", in_ready_o, in_ready_e);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_generate();
    int lat;
    run_word(16'h0000, 1'b0, 4'h0, lat);
    tests_run++;
    if (lat !== 5) begin
      tests_failed++;
      $display("FAIL gen0_latency: got %0d cycles, expected 5", lat);
    end
    tests_run++;
    if (out_parity_o !== 4'b1111 || out_err_o !== 4'b0000 || out_parity_e !== 4'b0000) begin
      tests_failed++;
      $display("FAIL gen0_parity: odd=%b err=%b even=%b, expected 1111 0000 0000",
               out_parity_o, out_err_o, out_parity_e);
    end
    release_out();
    tests_run++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL gen0_release: valid=%b in_ready=%b, expected 0 1", out_valid_o, in_ready_o);
    end
    $display("[TB] generate 0000 -> parity %b latency %0d", out_parity_o, lat);

    run_word(16'h1373, 1'b0, 4'hF, lat);
    tests_run++;
    if (out_parity_o !== 4'b0101 || out_data_o !== 16'h1373 || out_err_o !== 4'b0000 ||
        out_parity_e !== 4'b1010) begin
      tests_failed++;
      $display("FAIL gen1373: par=%b data=%h err=%b even=%b, expected 0101 1373 0000 1010",
               out_parity_o, out_data_o, out_err_o, out_parity_e);
    end
    release_out();
    tick();
    tests_run++;
    if (out_data_o !== 16'h1373 || out_parity_o !== 4'b0101 || out_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_hold: data=%h par=%b valid=%b, expected 1373 0101 0",
               out_data_o, out_parity_o, out_valid_o);
    end
    $display("[TB] generate 1373 -> parity %b", out_parity_o);
  endtask

  task automatic test_check();
    int lat;
    run_word(16'h1373, 1'b1, 4'b0111, lat);
    tests_run++;
    if (out_parity_o !== 4'b0101 || out_err_o !== 4'b0010) begin
      tests_failed++;
      $display("FAIL check_odd: par=%b err=%b, expected 0101 0010", out_parity_o, out_err_o);
    end
    tests_run++;
    if (out_parity_e !== 4'b1010 || out_err_e !== 4'b1101) begin
      tests_failed++;
      $display("FAIL check_even: par=%b err=%b, expected 1010 1101", out_parity_e, out_err_e);
    end
    release_out();
    $display("[TB] check 1373 exp 0111 -> err %b", out_err_o);
  endtask

  task automatic test_backpressure();
    int lat;
    logic stable_ok, ready_ok;
    run_word(16'h9C3E, 1'b0, 4'h0, lat);
    in_valid = 1'b1; in_data = 16'hABCD; in_mode = 1'b1; in_parity = 4'b0101;
    stable_ok = 1'b1; ready_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid_o !== 1'b1 || out_data_o !== 16'h9C3E ||
          out_parity_o !== model_par(16'h9C3E, 1'b1) || out_err_o !== 4'h0) stable_ok = 1'b0;
      if (in_ready_o !== 1'b0) ready_ok = 1'b0;
    end
    tests_run++;
    if (!stable_ok) begin
      tests_failed++;
      $display("FAIL bp_stable: valid=%b data=%h par=%b, expected 1 9c3e %b",
               out_valid_o, out_data_o, out_parity_o, model_par(16'h9C3E, 1'b1));
    end
    tests_run++;
    if (!ready_ok) begin
      tests_failed++;
      $display("FAIL bp_in_ready: in_ready=%b during DONE, expected 0", in_ready_o);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_after_hs: in_ready=%b busy=%b valid=%b, expected 1 0 0",
               in_ready_o, busy_o, out_valid_o);
    end
    run_word(16'hABCD, 1'b1, 4'b0101, lat);
    tests_run++;
    if (out_data_o !== 16'hABCD || out_err_o !== (model_par(16'hABCD, 1'b1) ^ 4'b0101)) begin
      tests_failed++;
      $display("FAIL bp_new_word: data=%h err=%b, expected abcd %b",
               out_data_o, out_err_o, model_par(16'hABCD, 1'b1) ^ 4'b0101);
    end
    release_out();
    $display("[TB] backpressure held 6 cycles, next word %h accepted", out_data_o);
  endtask

  task automatic test_back_to_back();
    logic [15:0] words[2];
    int acc_cyc[$];
    int nsent, nrecv, cyc;
    words[0] = 16'hFFFF; words[1] = 16'h8421;
    nsent = 0; nrecv = 0; cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = words[0]; in_mode = 1'b0;
    while (nrecv < 2 && cyc < 60) begin
      if (out_valid_o) begin
        tests_run++;
        if (out_parity_o !== model_par(words[nrecv], 1'b1) ||
            out_parity_e !== model_par(words[nrecv], 1'b0)) begin
          tests_failed++;
          $display("FAIL b2b_word%0d: odd=%b even=%b, expected %b %b", nrecv,
                   out_parity_o, out_parity_e, model_par(words[nrecv], 1'b1),
                   model_par(words[nrecv], 1'b0));
        end
        $display("[TB] b2b word %h -> odd %b even %b", words[nrecv], out_parity_o, out_parity_e);
        nrecv++;
      end
      if (in_valid && in_ready_o) begin
        acc_cyc.push_back(cyc);
        nsent++;
      end
      tick();
      cyc++;
      if (nsent < 2) in_data = words[nsent];
      else in_valid = 1'b0;
    end
    out_ready = 1'b0;
    tests_run++;
    if (nrecv != 2 || acc_cyc.size() != 2) begin
      tests_failed++;
      $display("FAIL b2b_count: received %0d accepted %0d, expected 2 2", nrecv, acc_cyc.size());
    end else if (acc_cyc[1] - acc_cyc[0] != 6) begin
      tests_failed++;
      $display("FAIL b2b_spacing: got %0d cycles, expected 6", acc_cyc[1] - acc_cyc[0]);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] w;
    logic m;
    logic [3:0] p, eo, ee;
    for (int t = 0; t < 20; t++) begin
      w = 16'($urandom); m = 1'($urandom); p = 4'($urandom);
      run_word(w, m, p, lat);
      eo = m ? (model_par(w, 1'b1) ^ p) : 4'h0;
      ee = m ? (model_par(w, 1'b0) ^ p) : 4'h0;
      tests_run++;
      if (lat !== 5 || out_data_o !== w || out_parity_o !== model_par(w, 1'b1) ||
          out_err_o !== eo || out_data_e !== w || out_parity_e !== model_par(w, 1'b0) ||
          out_err_e !== ee) begin
        tests_failed++;
        $display("FAIL rand%0d: lat=%0d data=%h par=%b/%b err=%b/%b, expected 5 %h %b/%b %b/%b",
                 t, lat, out_data_o, out_parity_o, out_parity_e, out_err_o, out_err_e,
                 w, model_par(w, 1'b1), model_par(w, 1'b0), eo, ee);
      end
      $display("[TB] rand %0d word %h mode %0d -> par %b err %b", t, w, m, out_parity_o, out_err_o);
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
      release_out();
    end
  endtask

  task automatic test_reset_midstream();
    logic stale;
    in_data = 16'h5A5A; in_mode = 1'b1; in_parity = 4'h3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || out_data_o !== 16'h0 ||
        out_parity_o !== 4'h0 || out_err_o !== 4'h0 || out_data_e !== 16'h0) begin
      tests_failed++;
      $display("FAIL midreset_clear: busy=%b valid=%b data=%h par=%b err=%b, expected all 0",
               busy_o, out_valid_o, out_data_o, out_parity_o, out_err_o);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (in_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_ready: in_ready=%b, expected 1", in_ready_o);
    end
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid_o || out_valid_e) stale = 1'b1;
      tick();
    end
    tests_run++;
    if (stale) begin
      tests_failed++;
      $display("FAIL midreset_stale: out_valid seen=%b, expected 0", stale);
    end
    $display("[TB] reset mid-stream at idx 2 discarded word");
  endtask

  initial begin
    test_reset();
    test_generate();
    test_check();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
